dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined RISC-V core: the slave end of the core's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and performs byte, half or word access into internal word-organised storage. It returns a single-cycle response after a fixed, parameterised latency, which lets the M stage be verified against a memory with real wait states.

## Interface
Parameters:
- DEPTH_WORDS, 16384: storage depth in 32-bit words (64 KiB).
- BASE_ADDR, 32'h0: byte address of word 0. Must be 4-byte aligned.
- LATENCY, 2: cycles from request acceptance to response. Legal range 1..15.

Ports:
- clk  in  1: single clock, all state on rising edge.
- rst  in  1: synchronous, active-high reset.
- req_valid  in  1: request present.
- req_ready  out  1: responder can accept a request.
- req_rw  in  1: 0 = read (load), 1 = write (store).
- req_addr  in  32: byte address.
- req_size  in  2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_wdata  in  32: store data, right-justified.
- rsp_valid  out  1: response pulse, one cycle.
- rsp_rdata  out  32: load data, right-justified, zero-extended. The requester performs sign extension.
- rsp_err  out  1: access error, qualified by rsp_valid.

## Operation
- FSM states: IDLE, WAIT, RESP. The reset state is IDLE.
- req_ready = (state == IDLE) && !rst.
- Acceptance happens in a cycle where req_valid && req_ready. At acceptance the block captures rw, addr, size and wdata.
- Transition out of IDLE on acceptance:
  - to RESP if LATENCY == 1;
  - otherwise to WAIT, with the down-counter loaded to LATENCY-2.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 0.
- RESP: go to IDLE unconditionally.
- Memory access is performed on the clock edge that enters RESP.
  - Reads: data is registered and driven during RESP.
  - Writes: committed on that edge.
- Byte lanes:
  - Byte access uses lane addr[1:0].
  - Half access uses lanes {addr[1],0}..+1.
  - Word access uses all lanes.
  - Stores write only the addressed lanes, from wdata[7:0], wdata[15:0] or wdata[31:0].
  - Loads shift the addressed lanes to bit 0 and zero the upper bits.
- Word index = (addr - BASE_ADDR) >> 2.
- A write response has rsp_valid=1 and rsp_rdata=0.
- Errored accesses do not modify storage and return rsp_rdata=0. Error conditions are listed under Configuration.
- Storage contents are not reset. Contents are undefined until written.
- Requests presented while req_ready=0 are ignored. The requester must hold them until accepted.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, counter=0.
- req_ready is 0 during reset and 1 in the first cycle after reset deasserts.
- Acceptance in cycle n gives rsp_valid=1 in cycle n+LATENCY only. rsp_valid is 0 in every other cycle.
- req_ready is 0 from cycle n+1 through n+LATENCY and returns to 1 in cycle n+LATENCY+1.
- Throughput is one request per LATENCY+1 cycles.
- rsp_rdata and rsp_err hold their values after the pulse until the next response.
- A request accepted in cycle n+LATENCY+1 observes any write committed by the previous request (read-after-write is coherent).
- Reset asserted in WAIT or RESP:
  - The pending request is dropped.
  - No response is issued.
  - No write is committed unless the commit edge already occurred.

## Configuration
- DMEM_ERR_EN defined:
  - rsp_err=1 for: req_size==3; half access with addr[0]=1; word access with addr[1:0]!=0; addr < BASE_ADDR; or word index >= DEPTH_WORDS.
  - On error, storage is untouched and rsp_rdata=0.
- DMEM_ERR_EN undefined:
  - rsp_err is tied to 0.
  - Half access ignores addr[0]; word access ignores addr[1:0] (aligned down).
  - size 3 is treated as word.
  - Word index wraps modulo DEPTH_WORDS.
  - No access is suppressed.

## Test plan
- Word write then read, LATENCY=2: write 0xDEADBEEF to 0x10, then read 0x10. Each rsp_valid pulses exactly 2 cycles after acceptance; the read returns 0xDEADBEEF with rsp_err=0. req_ready is low for 2 cycles after each acceptance.
- Byte and half lanes: word 0x11223344 at 0x20; sb 0xAA to 0x22; sh 0xBEEF to 0x20. Word read returns 0x11AABEEF; lb 0x23 returns 0x00000011; lh 0x22 returns 0x000011AA.
- Errors with DMEM_ERR_EN: sw to 0x21, lh at 0x23, size 3, and a read at BASE_ADDR+DEPTH_WORDS*4. Each returns rsp_err=1 and rdata=0; a follow-up read of 0x20 shows unchanged data. Without the macro, sw to 0x21 writes word 0x20 with rsp_err=0.
- LATENCY=1 back-to-back: hold req_valid high with 4 reads. Acceptances occur every 2 cycles and rsp_valid pulses every 2 cycles, each 1 cycle after its acceptance.
- Reset mid-operation: accept a write of 0x55 to 0x30, assert rst in the WAIT cycle. No rsp_valid; 0x30 keeps its old value; req_ready=1 the cycle after rst drops.
- Ignored request: drive req_valid with a different address while in WAIT. It is not accepted and does not corrupt the in-flight response.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, fixed-latency single-cycle response,
// byte/half/word access to word-organised storage. Define DMEM_ERR_EN for access error checking.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        rw_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;

  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        accept;
  logic        commit;

  logic        acc_rw;
  logic [31:0] acc_addr;
  logic [1:0]  acc_size;
  logic [31:0] acc_wdata;

  logic [1:0]  eff_size;
  logic [31:0] widx;
  logic [AW-1:0] mem_idx;
  logic        err;
  logic [1:0]  lane;
  logic [3:0]  be_base;
  logic [3:0]  be;
  logic [31:0] wshift;
  logic [31:0] rword;
  logic [31:0] rshift;
  logic [31:0] rload;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP) && !rst;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The access edge is the one entering RESP; with LATENCY==1 that is the
  // acceptance edge itself, so the live request is used instead of the capture.
  assign commit = (state_d == RESP) && (state_q != RESP) && !rst;

  always_comb begin
    if (state_q == IDLE) begin
      acc_rw    = req_rw;
      acc_addr  = req_addr;
      acc_size  = req_size;
      acc_wdata = req_wdata;
    end else begin
      acc_rw    = rw_q;
      acc_addr  = addr_q;
      acc_size  = size_q;
      acc_wdata = wdata_q;
    end
  end

`ifdef DMEM_ERR_EN
  logic [32:0] diff;
  always_comb begin
    diff     = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
    widx     = diff[31:0] >> 2;
    eff_size = acc_size;
    err      = (acc_size == 2'd3)
            || ((acc_size == 2'd1) && acc_addr[0])
            || ((acc_size == 2'd2) && (acc_addr[1:0] != 2'b00))
            || diff[32]
            || (widx >= DEPTH_WORDS);
  end
`else
  always_comb begin
    widx     = ((acc_addr - BASE_ADDR) >> 2) % DEPTH_WORDS;
    eff_size = (acc_size == 2'd3) ? 2'd2 : acc_size;
    err      = 1'b0;
  end
`endif

  assign mem_idx = AW'(widx);

  always_comb begin
    lane    = 2'd0;
    be_base = 4'b1111;
    unique case (eff_size)
      2'd0: begin
        lane    = acc_addr[1:0];
        be_base = 4'b0001;
      end
      2'd1: begin
        lane    = {acc_addr[1], 1'b0};
        be_base = 4'b0011;
      end
      default: begin
        lane    = 2'd0;
        be_base = 4'b1111;
      end
    endcase
  end

  assign be     = be_base << lane;
  assign wshift = acc_wdata << {lane, 3'b000};
  assign rword  = mem[mem_idx];
  assign rshift = rword >> {lane, 3'b000};

  always_comb begin
    unique case (eff_size)
      2'd0:    rload = {24'h0, rshift[7:0]};
      2'd1:    rload = {16'h0, rshift[15:0]};
      default: rload = rshift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rw_q    <= req_rw;
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        rsp_err_q   <= err;
        rsp_rdata_q <= (acc_rw || err) ? '0 : rload;
      end
    end
  end

  // Storage is deliberately not reset; commit already excludes reset cycles.
  always_ff @(posedge clk) begin
    if (commit && acc_rw && !err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[mem_idx][8*b +: 8] <= wshift[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for vectors and corner
// sequences, LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, req_rw;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid1, req_ready1, req_rw1;
  logic [31:0] req_addr1, req_wdata1;
  logic [1:0]  req_size1;
  logic        rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(16384), .BASE_ADDR(32'h0), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_rw(req_rw1),
    .req_addr(req_addr1), .req_size(req_size1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err);
    vec_t v;
    v.rw = rw; v.addr = addr; v.size = size; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // One transaction on the LATENCY=2 instance, checking handshake timing on the way.
  task automatic do_req(input string tag, input logic rw, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
    int waited;
    rdata = '0;
    err   = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_size = size; req_wdata = wdata;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk1({tag, " accept_timeout"}, req_ready, 1'b1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      chk1($sformatf("%s ready_low_c%0d", tag, k), req_ready, 1'b0);
      chk1($sformatf("%s rsp_valid_c%0d", tag, k), rsp_valid, (k == LAT));
      if (k == LAT) begin
        rdata = rsp_rdata;
        err   = rsp_err;
      end
      @(negedge clk);
    end
    chk1({tag, " ready_back"}, req_ready, 1'b1);
    chk1({tag, " rsp_valid_after"}, rsp_valid, 1'b0);
    chk32({tag, " rdata_hold"}, rsp_rdata, rdata);
  endtask

  task automatic burst1(input logic rw);
    string tag;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      tag = $sformatf("lat1_%s_c%0d", rw ? "wr" : "rd", k);
      if (k < 8 && (k % 2) == 0) begin
        req_valid1 = 1'b1; req_rw1 = rw; req_addr1 = 32'(4 * (k / 2)); req_size1 = 2'd2;
        req_wdata1 = 32'hA500_0000 | 32'(k / 2);
      end else if (k == 8) begin
        req_valid1 = 1'b0;
      end
      chk1({tag, " ready"}, req_ready1, ((k % 2) == 0));
      chk1({tag, " rsp_valid"}, rsp_valid1, ((k % 2) == 1));
      if ((k % 2) == 1) begin
        chk32({tag, " rdata"}, rsp_rdata1, rw ? 32'h0 : (32'hA500_0000 | 32'(k / 2)));
        chk1({tag, " err"}, rsp_err1, 1'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] c20;

    rst = 1'b1;
    req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    req_valid1 = 1'b0; req_rw1 = 1'b0; req_addr1 = '0; req_size1 = '0; req_wdata1 = '0;

    vecs.push_back(mk(1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h10, 2'd2, 32'h0,        32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b1, 32'h20, 2'd2, 32'h11223344, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 32'h22, 2'd0, 32'h123456AA, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 32'h20, 2'd1, 32'h9999BEEF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h20, 2'd2, 32'h0,        32'h11AABEEF, 1'b0));
    vecs.push_back(mk(1'b0, 32'h23, 2'd0, 32'h0,        32'h00000011, 1'b0));
    vecs.push_back(mk(1'b0, 32'h22, 2'd1, 32'h0,        32'h000011AA, 1'b0));
    vecs.push_back(mk(1'b0, 32'h21, 2'd0, 32'h0,        32'h000000BE, 1'b0));
    vecs.push_back(mk(1'b0, 32'h20, 2'd0, 32'h0,        32'h000000EF, 1'b0));
`ifdef DMEM_ERR_EN
    vecs.push_back(mk(1'b1, 32'h21,    2'd2, 32'hCAFEF00D, 32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 32'h23,    2'd1, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 32'h20,    2'd3, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 32'h10000, 2'd2, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 32'h20,    2'd2, 32'h0,        32'h11AABEEF, 1'b0));
    c20 = 32'h11AABEEF;
`else
    vecs.push_back(mk(1'b1, 32'h21,    2'd2, 32'hCAFEF00D, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 32'h20,    2'd2, 32'h0,        32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(1'b0, 32'h23,    2'd1, 32'h0,        32'h0000CAFE, 1'b0));
    vecs.push_back(mk(1'b0, 32'h20,    2'd3, 32'h0,        32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(1'b0, 32'h10010, 2'd2, 32'h0,        32'hDEADBEEF, 1'b0));
    c20 = 32'hCAFEF00D;
`endif

    repeat (3) @(negedge clk);
    chk1("reset ready", req_ready, 1'b0);
    chk1("reset rsp_valid", rsp_valid, 1'b0);
    chk32("reset rdata", rsp_rdata, 32'h0);
    chk1("reset err", rsp_err, 1'b0);
    chk1("reset ready1", req_ready1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("post_reset ready", req_ready, 1'b1);
    chk1("post_reset rsp_valid", rsp_valid, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, er);
      chk32($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      chk1($sformatf("vec%0d err", i), er, vecs[i].exp_err);
    end

    // Request driven while busy must be ignored and leave the in-flight read intact.
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_wdata = '0;
    chk1("ign accept_ready", req_ready, 1'b1);
    @(negedge clk);
    req_rw = 1'b1; req_addr = 32'h20; req_wdata = 32'h0;
    chk1("ign wait_ready", req_ready, 1'b0);
    chk1("ign wait_valid", rsp_valid, 1'b0);
    @(negedge clk);
    chk1("ign rsp_valid", rsp_valid, 1'b1);
    chk32("ign rdata", rsp_rdata, 32'hDEADBEEF);
    chk1("ign err", rsp_err, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    chk1("ign ready_back", req_ready, 1'b1);
    chk1("ign valid_after", rsp_valid, 1'b0);
    do_req("ign_chk", 1'b0, 32'h20, 2'd2, 32'h0, rd, er);
    chk32("ign mem_0x20", rd, c20);

    burst1(1'b1);
    burst1(1'b0);

    // Reset in WAIT drops the pending store.
    do_req("rst_pre", 1'b1, 32'h30, 2'd2, 32'h12345678, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h30; req_size = 2'd2; req_wdata = 32'h55;
    chk1("rst accept_ready", req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    chk1("rst wait_valid", rsp_valid, 1'b0);
    @(negedge clk);
    chk1("rst in_reset_ready", req_ready, 1'b0);
    chk1("rst in_reset_valid", rsp_valid, 1'b0);
    chk32("rst in_reset_rdata", rsp_rdata, 32'h0);
    chk1("rst in_reset_err", rsp_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("rst ready_after", req_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("rst no_rsp_c%0d", k), rsp_valid, 1'b0);
      @(negedge clk);
    end
    do_req("rst_chk", 1'b0, 32'h30, 2'd2, 32'h0, rd, er);
    chk32("rst mem_0x30", rd, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
